// File: rtl/character_controller.sv
`default_nettype none
// ============================================================================
// Module      : character_controller
// Description : Frame-rate movement, attack sequencing and hitstun for one
//               player. Optional attack buffering is enabled by ATTACK_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module character_controller #(
    parameter int PLAYER_NUM     = 0,
    parameter int START_X        = 64,
    parameter int Y_GROUND       = 240,
    parameter int CHAR_W         = 64,
    parameter int X_MAX          = 576,
    parameter int FWD_SPEED      = 3,
    parameter int BACK_SPEED     = 2,
    parameter int N_STARTUP      = 5,
    parameter int N_ACTIVE       = 2,
    parameter int N_RECOVERY     = 16,
    parameter int D_STARTUP      = 4,
    parameter int D_ACTIVE       = 3,
    parameter int D_RECOVERY     = 15,
    parameter int HITSTUN_FRAMES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic [9:0] opp_x,
    input  logic       hit_in,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       attacking,
    output logic       dir_attacking,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_FWD  = 3'd1,
        ST_MOVE_BACK = 3'd2,
        ST_HITSTUN   = 3'd3,
        ST_STARTUP   = 3'd5,
        ST_ACTIVE    = 3'd6,
        ST_RECOVERY  = 3'd7
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_n_startup   = CNT_W'(N_STARTUP - 1);
    localparam logic [CNT_W-1:0] c_n_active    = CNT_W'(N_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_n_recovery  = CNT_W'(N_RECOVERY - 1);
    localparam logic [CNT_W-1:0] c_d_startup   = CNT_W'(D_STARTUP - 1);
    localparam logic [CNT_W-1:0] c_d_active    = CNT_W'(D_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_d_recovery  = CNT_W'(D_RECOVERY - 1);
    localparam logic [CNT_W-1:0] c_hitstun     = CNT_W'(HITSTUN_FRAMES - 1);
    localparam logic signed [11:0] c_fwd       = 12'(FWD_SPEED);
    localparam logic signed [11:0] c_back      = 12'(BACK_SPEED);
    localparam logic signed [11:0] c_char_w    = 12'(CHAR_W);
    localparam logic signed [11:0] c_x_max     = 12'(X_MAX);
    localparam logic [9:0]         c_x_max_u   = 10'(X_MAX);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [9:0]       r_x, w_x_nxt;
    logic             r_attacking, w_att_nxt;
    logic             r_dir_attacking, w_dir_nxt;
    logic             r_attack_prev;
    logic             r_hit_pending;

    logic             w_attack_edge;
    logic             w_one_dir;
    logic             w_fwd_held;
    logic signed [11:0] w_step;
    logic signed [11:0] w_x_sum;
    logic signed [11:0] w_opp_lim;
    logic [9:0]       w_x_arena;
    logic [9:0]       w_lim;
    logic [9:0]       w_x_moved;

`ifdef ATTACK_BUFFER_EN
    logic             r_buf_valid, w_buf_valid_nxt;
    logic             r_buf_dir, w_buf_dir_nxt;
    logic             w_buf_take;
    logic             w_buf_dir_sel;
`endif

    assign w_attack_edge = btn_attack & ~r_attack_prev;
    assign w_one_dir     = btn_left ^ btn_right;

    // Arena clamp in wide signed arithmetic so underflow never wraps.
    always_comb begin
        w_x_sum = signed'({2'b00, r_x}) + w_step;
        if (w_x_sum < 12'sd0) begin
            w_x_arena = 10'd0;
        end else if (w_x_sum > c_x_max) begin
            w_x_arena = c_x_max_u;
        end else begin
            w_x_arena = w_x_sum[9:0];
        end
    end

    generate
        if (PLAYER_NUM == 0) begin : g_left_player
            assign w_fwd_held = btn_right;
            assign w_step     = btn_right ? c_fwd : -c_back;
            // Stay at least one sprite width to the left of the opponent.
            always_comb begin
                w_opp_lim = signed'({2'b00, opp_x}) - c_char_w;
                w_lim     = (w_opp_lim < 12'sd0) ? 10'd0 : w_opp_lim[9:0];
                w_x_moved = (w_x_arena > w_lim) ? w_lim : w_x_arena;
            end
        end else begin : g_right_player
            assign w_fwd_held = btn_left;
            assign w_step     = btn_left ? -c_fwd : c_back;
            // Stay at least one sprite width to the right of the opponent.
            always_comb begin
                w_opp_lim = signed'({2'b00, opp_x}) + c_char_w;
                w_lim     = (w_opp_lim > c_x_max) ? c_x_max_u : w_opp_lim[9:0];
                w_x_moved = (w_x_arena < w_lim) ? w_lim : w_x_arena;
            end
        end
    endgenerate

`ifdef ATTACK_BUFFER_EN
    assign w_buf_take    = r_buf_valid | w_attack_edge;
    assign w_buf_dir_sel = r_buf_valid ? r_buf_dir : w_one_dir;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_att_nxt   = r_attacking;
        w_dir_nxt   = r_dir_attacking;
`ifdef ATTACK_BUFFER_EN
        w_buf_valid_nxt = r_buf_valid;
        w_buf_dir_nxt   = r_buf_dir;
`endif
        if (r_hit_pending) begin
            w_state_nxt = ST_HITSTUN;
            w_cnt_nxt   = c_hitstun;
            w_att_nxt   = 1'b0;
            w_dir_nxt   = 1'b0;
`ifdef ATTACK_BUFFER_EN
            w_buf_valid_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_HITSTUN: begin
                    if (r_cnt == '0) w_state_nxt = ST_IDLE;
                    else             w_cnt_nxt   = r_cnt - c_cnt_one;
                end
                ST_STARTUP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = r_dir_attacking ? c_d_active : c_n_active;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                ST_ACTIVE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RECOVERY;
                        w_cnt_nxt   = r_dir_attacking ? c_d_recovery : c_n_recovery;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
`ifdef ATTACK_BUFFER_EN
                    if (w_attack_edge) begin
                        w_buf_valid_nxt = 1'b1;
                        w_buf_dir_nxt   = w_one_dir;
                    end
`endif
                end
                ST_RECOVERY: begin
                    if (r_cnt == '0) begin
`ifdef ATTACK_BUFFER_EN
                        if (w_buf_take) begin
                            w_state_nxt     = ST_STARTUP;
                            w_dir_nxt       = w_buf_dir_sel;
                            w_att_nxt       = ~w_buf_dir_sel;
                            w_cnt_nxt       = w_buf_dir_sel ? c_d_startup : c_n_startup;
                            w_buf_valid_nxt = 1'b0;
                        end else begin
`else
                        begin
`endif
                            w_state_nxt = ST_IDLE;
                            w_att_nxt   = 1'b0;
                            w_dir_nxt   = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
`ifdef ATTACK_BUFFER_EN
                        if (w_attack_edge) begin
                            w_buf_valid_nxt = 1'b1;
                            w_buf_dir_nxt   = w_one_dir;
                        end
`endif
                    end
                end
                default: begin
                    // IDLE and MOVE_*: an attack edge wins over movement.
                    if (w_attack_edge) begin
                        w_state_nxt = ST_STARTUP;
                        w_dir_nxt   = w_one_dir;
                        w_att_nxt   = ~w_one_dir;
                        w_cnt_nxt   = w_one_dir ? c_d_startup : c_n_startup;
                    end else if (w_one_dir) begin
                        w_state_nxt = w_fwd_held ? ST_MOVE_FWD : ST_MOVE_BACK;
                        w_x_nxt     = w_x_moved;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_x             <= 10'(START_X);
            r_attacking     <= 1'b0;
            r_dir_attacking <= 1'b0;
            r_attack_prev   <= 1'b0;
            r_hit_pending   <= 1'b0;
        end else if (frame_tick) begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_x             <= w_x_nxt;
            r_attacking     <= w_att_nxt;
            r_dir_attacking <= w_dir_nxt;
            r_attack_prev   <= btn_attack;
            r_hit_pending   <= hit_in;
        end else if (hit_in) begin
            r_hit_pending   <= 1'b1;
        end
    end

`ifdef ATTACK_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_dir   <= 1'b0;
        end else if (frame_tick) begin
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_dir   <= w_buf_dir_nxt;
        end
    end
`endif

    assign x_pos         = r_x;
    assign y_pos         = 10'(Y_GROUND);
    assign attacking     = r_attacking;
    assign dir_attacking = r_dir_attacking;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_character_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_character_controller
// Description : Directed self-checking bench for both player orientations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_character_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       left0 = 1'b0, right0 = 1'b0, atk0 = 1'b0, hit0 = 1'b0;
    logic       left1 = 1'b0, right1 = 1'b0, atk1 = 1'b0, hit1 = 1'b0;
    logic [9:0] opp_x0 = 10'd1000;
    logic [9:0] opp_x1 = 10'd0;
    logic [9:0] x0, y0, x1, y1;
    logic       att0, dat0, att1, dat1;
    logic [2:0] st0, st1;

    int total = 0;
    int bad   = 0;
    int exp_st;
    int exp_buf_st;
    int exp_buf_att;

    always #5 clk = ~clk;

    character_controller #(.PLAYER_NUM(0), .START_X(64)) u_p0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_left(left0), .btn_right(right0), .btn_attack(atk0),
        .opp_x(opp_x0), .hit_in(hit0),
        .x_pos(x0), .y_pos(y0), .attacking(att0), .dir_attacking(dat0), .state(st0)
    );

    character_controller #(.PLAYER_NUM(1), .START_X(512)) u_p1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_left(left1), .btn_right(right1), .btn_attack(atk1),
        .opp_x(opp_x1), .hit_in(hit1),
        .x_pos(x1), .y_pos(y1), .attacking(att1), .dir_attacking(dat1), .state(st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick; returns at the following falling edge with tick low.
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    // hit_in pulse on a clock that carries no frame tick.
    task automatic hit_p0();
        hit0 = 1'b1;
        @(negedge clk) hit0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ATTACK_BUFFER_EN
        exp_buf_st  = 5;
        exp_buf_att = 1;
`else
        exp_buf_st  = 0;
        exp_buf_att = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_x0", x0, 64);
        chk("rst_y0", y0, 240);
        chk("rst_st0", st0, 0);
        chk("rst_att0", att0, 0);
        chk("rst_dat0", dat0, 0);
        chk("rst_x1", x1, 512);
        chk("rst_st1", st1, 0);
        rst_n = 1'b1;

        // Walk forward then backward
        right0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("walk_fwd_x", x0, 64 + 3 * i);
        end
        chk("walk_fwd_st", st0, 1);
        right0 = 1'b0; left0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("walk_back_x", x0, 94 - 2 * i);
        end
        chk("walk_back_st", st0, 2);
        left0 = 1'b0;
        tick();
        chk("idle_st", st0, 0);
        chk("idle_x", x0, 84);

        // Neutral attack with the button held throughout
        atk0 = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            tick();
            exp_st = (i <= 5) ? 5 : ((i <= 7) ? 6 : 7);
            chk("neu_st", st0, exp_st);
            chk("neu_att", att0, 1);
            chk("neu_dat", dat0, 0);
        end
        tick();
        chk("neu_end_st", st0, 0);
        chk("neu_end_att", att0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("neu_hold_st", st0, 0);
        end
        atk0 = 1'b0;
        tick();

        // Directional attack (right held) runs 4/3/15 and never moves
        atk0 = 1'b1; right0 = 1'b1;
        tick();
        chk("dir_st1", st0, 5);
        chk("dir_dat1", dat0, 1);
        chk("dir_att1", att0, 0);
        chk("dir_nomove", x0, 84);
        atk0 = 1'b0; right0 = 1'b0;
        for (int i = 2; i <= 22; i++) begin
            tick();
            exp_st = (i <= 4) ? 5 : ((i <= 7) ? 6 : 7);
            chk("dir_st", st0, exp_st);
            chk("dir_dat", dat0, 1);
        end
        tick();
        chk("dir_end_st", st0, 0);
        chk("dir_end_dat", dat0, 0);
        chk("dir_end_x", x0, 84);

        // Directional attack (left held) struck on the 2nd ACTIVE tick
        atk0 = 1'b1; left0 = 1'b1;
        tick();
        atk0 = 1'b0; left0 = 1'b0;
        for (int i = 2; i <= 6; i++) tick();
        chk("hit_pre_st", st0, 6);
        hit_p0();
        tick();
        chk("hit_st", st0, 3);
        chk("hit_att", att0, 0);
        chk("hit_dat", dat0, 0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("stun_st", st0, 3);
        end
        tick();
        chk("stun_end_st", st0, 0);
        chk("stun_end_x", x0, 84);

        // Both directions + attack is neutral; re-hit mid-stun restarts stun
        atk0 = 1'b1; left0 = 1'b1; right0 = 1'b1;
        tick();
        chk("both_att", att0, 1);
        chk("both_dat", dat0, 0);
        atk0 = 1'b0; left0 = 1'b0; right0 = 1'b0;
        hit_p0();
        tick();
        chk("hit_su_st", st0, 3);
        chk("hit_su_att", att0, 0);
        repeat (5) tick();
        hit_p0();
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("restun_st", st0, 3);
        end
        tick();
        chk("restun_end_st", st0, 0);

        // Attack press on RECOVERY tick 10
        atk0 = 1'b1;
        tick();
        atk0 = 1'b0;
        for (int i = 2; i <= 16; i++) tick();
        atk0 = 1'b1;
        tick();
        chk("buf_press_st", st0, 7);
        atk0 = 1'b0;
        for (int i = 18; i <= 23; i++) tick();
        chk("buf_last_rec", st0, 7);
        tick();
        chk("buf_after_st", st0, exp_buf_st);
        chk("buf_after_att", att0, exp_buf_att);
        hit_p0();
        repeat (12) tick();
        tick();
        chk("buf_clear_st", st0, 0);

        // Asynchronous reset in the middle of an attack
        atk0 = 1'b1;
        tick();
        atk0 = 1'b0;
        tick();
        tick();
        chk("pre_arst_st", st0, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", x0, 64);
        chk("arst_y", y0, 240);
        chk("arst_st", st0, 0);
        chk("arst_att", att0, 0);
        chk("arst_dat", dat0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Left arena edge
        right0 = 1'b1;
        tick();
        chk("edge_prep", x0, 67);
        right0 = 1'b0; left0 = 1'b1;
        repeat (33) tick();
        chk("edge_x1", x0, 1);
        tick();
        chk("edge_x0", x0, 0);
        chk("edge_st", st0, 2);
        tick();
        chk("edge_hold", x0, 0);
        left0 = 1'b0;

        // Opponent spacing for the left player
        right0 = 1'b1;
        repeat (168) tick();
        chk("run_x", x0, 504);
        right0 = 1'b0; left0 = 1'b1;
        repeat (2) tick();
        chk("opp_prep", x0, 500);
        left0 = 1'b0; opp_x0 = 10'd560; right0 = 1'b1;
        tick();
        chk("opp_clamp_x", x0, 496);
        chk("opp_clamp_st", st0, 1);
        tick();
        chk("opp_hold_x", x0, 496);
        right0 = 1'b0;

        // Right player: left is forward, right edge and opponent cap
        left1 = 1'b1;
        tick();
        chk("p1_fwd_x", x1, 509);
        chk("p1_fwd_st", st1, 1);
        left1 = 1'b0; right1 = 1'b1;
        repeat (33) tick();
        chk("p1_back_x", x1, 575);
        chk("p1_back_st", st1, 2);
        tick();
        chk("p1_xmax", x1, 576);
        right1 = 1'b0; opp_x1 = 10'd520; left1 = 1'b1;
        tick();
        chk("p1_opp_cap", x1, 576);
        chk("p1_opp_st", st1, 1);
        left1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
